// File: rtl/data_capture_pkg.sv
// Shared constants for the data_capture block.
//   TS_WIDTH      : width of the optional cycle timestamp stored with each word
//   DEFAULT_WIDTH : default captured word width
//   DEFAULT_DEPTH : default FIFO depth (power of two, 2..16)
package data_capture_pkg;

  localparam int unsigned TS_WIDTH      = 16;
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/data_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   push_i, wdata_i  : write request and word; a push into a full FIFO is
//                      accepted only when a pop happens on the same edge
//   pop_i            : remove head (ignored when empty)
//   clr_i            : synchronous flush, overrides push and pop
//   rd_valid_o       : head valid
//   rd_data_o        : head word
//   level_o          : number of stored words, 0..DEPTH
//   full_c           : level equals DEPTH (combinational from level)
module data_capture_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    push_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic                    pop_i,
  input  logic                    clr_i,
  output logic                    rd_valid_o,
  output logic [DW-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [DW-1:0] head_q, head_d;
  logic          valid_q;
  logic          pop_ok, push_ok;

  assign full_c  = (lvl_q == LW'(DEPTH));
  assign pop_ok  = pop_i && valid_q;
  assign push_ok = push_i && (!full_c || pop_ok);
  assign rd_nxt  = rd_q + PW'(1);

  // Next pointers, level and head word; the head is kept in its own register
  // so the output does not go through the storage read mux.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    head_d = head_q;
    if (clr_i) begin
      wr_d   = '0;
      rd_d   = '0;
      lvl_d  = '0;
      head_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_nxt;
      lvl_d = lvl_q + LW'(push_ok) - LW'(pop_ok);
      if (pop_ok) begin
        // Next head is already stored unless only one word was left.
        if (lvl_q >= LW'(2))  head_d = mem_q[rd_nxt];
        else if (push_ok)     head_d = wdata_i;
        else                  head_d = '0;
      end else if (push_ok && !valid_q) begin
        head_d = wdata_i;
      end
    end
  end

  // Control state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      head_q  <= head_d;
      valid_q <= (lvl_d != '0);
    end
  end

  // Storage array; contents are meaningless outside the valid window.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_q] <= wdata_i;
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = head_q;
  assign level_o    = lvl_q;

endmodule

// File: rtl/data_capture.sv
// Change-capture front end: every edge the input word is compared with the
// previous one; changed words are queued in a FWFT FIFO while capture is on.
// Optional feature macro: DATA_CAPTURE_TIMESTAMP_EN adds a 16-bit free-running
// cycle counter whose value is stored with each word and returned on rd_time_o.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   data_in_i        : monitored data stream
//   capture_en_i     : enable capture of changed words
//   clr_i            : synchronous flush of FIFO and overflow flag
//   rd_valid_o/rd_ready_i/rd_data_o : FWFT read side
//   level_o          : FIFO fill level
//   overflow_o       : sticky, a change was dropped while full
//   rd_time_o        : (timestamp build only) capture cycle of rd_data_o
module data_capture
  import data_capture_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [WIDTH-1:0]       data_in_i,
  input  logic                   capture_en_i,
  input  logic                   clr_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
`ifdef DATA_CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]    rd_time_o
`endif
);

`ifdef DATA_CAPTURE_TIMESTAMP_EN
  localparam int unsigned DW = WIDTH + TS_WIDTH;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [WIDTH-1:0] prev_q;
  logic             ovf_q;
  logic             push, pop, full;
  logic [DW-1:0]    fifo_wdata, fifo_rdata;

  assign push = (data_in_i != prev_q) && capture_en_i;
  assign pop  = rd_valid_o && rd_ready_i;

`ifdef DATA_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] cnt_q;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_q + TS_WIDTH'(1);
  end

  assign fifo_wdata = {cnt_q, data_in_i};
  assign rd_time_o  = fifo_rdata[DW-1 -: TS_WIDTH];
`else
  assign fifo_wdata = data_in_i;
`endif

  assign rd_data_o = fifo_rdata[WIDTH-1:0];

  // Previous word and sticky overflow; prev_q tracks input even during clr.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= data_in_i;
      if (clr_i)                     ovf_q <= 1'b0;
      else if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign overflow_o = ovf_q;

  data_capture_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .push_i     (push),
    .wdata_i    (fifo_wdata),
    .pop_i      (pop),
    .clr_i      (clr_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (fifo_rdata),
    .level_o    (level_o),
    .full_c     (full)
  );

endmodule

// File: tb/tb_data_capture.sv
// Directed, table-driven bench for data_capture (DEPTH=4, WIDTH=32).
module tb_data_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic        capture_en;
  logic        clr;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [2:0]  level;
  logic        overflow;
`ifdef DATA_CAPTURE_TIMESTAMP_EN
  logic [15:0] rd_time;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_capture #(.DEPTH(4), .WIDTH(32)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .data_in_i    (data_in),
    .capture_en_i (capture_en),
    .clr_i        (clr),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_data_o    (rd_data),
    .level_o      (level),
    .overflow_o   (overflow)
`ifdef DATA_CAPTURE_TIMESTAMP_EN
    ,
    .rd_time_o    (rd_time)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic        en;
    logic        cl;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [2:0]  e_level;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [31:0] d, logic en, logic cl, logic rdy,
                              logic ev, logic [31:0] ed, logic [2:0] el, logic eo);
    vec_t v;
    v.d = d; v.en = en; v.cl = cl; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic ev, logic [31:0] ed, logic [2:0] el, logic eo);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(ev));
    check({tag, " level"},    32'(level),    32'(el));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    if (ev) check({tag, " rd_data"}, rd_data, ed);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // d, en, clr, rdy | valid, data, level, ovf
    vq.push_back(mk(32'hA5, 1, 0, 0, 1, 32'hA5, 1, 0));
    vq.push_back(mk(32'hA5, 1, 0, 1, 0, 32'h0,  0, 0));
    vq.push_back(mk(32'h1,  1, 0, 0, 1, 32'h1,  1, 0));
    vq.push_back(mk(32'h2,  1, 0, 0, 1, 32'h1,  2, 0));
    vq.push_back(mk(32'h3,  1, 0, 0, 1, 32'h1,  3, 0));
    vq.push_back(mk(32'h4,  1, 0, 0, 1, 32'h1,  4, 0));
    vq.push_back(mk(32'h5,  1, 0, 0, 1, 32'h1,  4, 1));
    vq.push_back(mk(32'h5,  1, 0, 1, 1, 32'h2,  3, 1));
    vq.push_back(mk(32'h5,  1, 0, 1, 1, 32'h3,  2, 1));
    vq.push_back(mk(32'h5,  1, 0, 1, 1, 32'h4,  1, 1));
    vq.push_back(mk(32'h5,  1, 0, 1, 0, 32'h0,  0, 1));
    vq.push_back(mk(32'h5,  1, 1, 0, 0, 32'h0,  0, 0));
    vq.push_back(mk(32'h6,  1, 0, 0, 1, 32'h6,  1, 0));
    vq.push_back(mk(32'h7,  1, 0, 0, 1, 32'h6,  2, 0));
    vq.push_back(mk(32'h8,  1, 0, 0, 1, 32'h6,  3, 0));
    vq.push_back(mk(32'h9,  1, 0, 0, 1, 32'h6,  4, 0));
    vq.push_back(mk(32'hA,  1, 0, 1, 1, 32'h7,  4, 0));
    vq.push_back(mk(32'hB,  1, 0, 1, 1, 32'h8,  4, 0));
    vq.push_back(mk(32'hB,  1, 0, 0, 1, 32'h8,  4, 0));
    vq.push_back(mk(32'hB,  1, 0, 1, 1, 32'h9,  3, 0));
    vq.push_back(mk(32'h1,  0, 0, 0, 1, 32'h9,  3, 0));
    vq.push_back(mk(32'h2,  0, 0, 0, 1, 32'h9,  3, 0));
    vq.push_back(mk(32'h2,  1, 1, 0, 0, 32'h0,  0, 0));
    vq.push_back(mk(32'h3,  1, 1, 0, 0, 32'h0,  0, 0));
    vq.push_back(mk(32'h3,  1, 0, 0, 0, 32'h0,  0, 0));
    vq.push_back(mk(32'h4,  1, 0, 0, 1, 32'h4,  1, 0));
    vq.push_back(mk(32'h4,  1, 0, 1, 0, 32'h0,  0, 0));
    vq.push_back(mk(32'h6,  1, 0, 1, 1, 32'h6,  1, 0));

    reset_n = 1'b0; data_in = '0; capture_en = 1'b1; clr = 1'b0; rd_ready = 1'b0;
    #12;
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset level",    32'(level),    32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset rd_data",  rd_data,       32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle input after reset release: nothing captured.
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_outs($sformatf("idle%0d", i), 1'b0, 32'h0, 3'd0, 1'b0);
    end

    foreach (vq[i]) begin
      data_in = vq[i].d; capture_en = vq[i].en; clr = vq[i].cl; rd_ready = vq[i].rdy;
      cycle();
      check_outs($sformatf("vec%0d", i), vq[i].e_valid, vq[i].e_data, vq[i].e_level, vq[i].e_ovf);
    end

    // Reset in the middle of operation drops content; prev_q restarts at 0.
    data_in = 32'h11; capture_en = 1'b1; clr = 1'b0; rd_ready = 1'b0;
    cycle();
    check_outs("pre_rst_a", 1'b1, 32'h6, 3'd2, 1'b0);
    data_in = 32'h22;
    cycle();
    check_outs("pre_rst_b", 1'b1, 32'h6, 3'd3, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst rd_valid", 32'(rd_valid), 32'h0);
    check("midrst level",    32'(level),    32'h0);
    check("midrst rd_data",  rd_data,       32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check_outs("post_rst", 1'b1, 32'h22, 3'd1, 1'b0);

`ifdef DATA_CAPTURE_TIMESTAMP_EN
    // Timestamp: change on the edge where the counter reads 7, then after wrap.
    reset_n = 1'b0; data_in = '0; rd_ready = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (7) cycle();
    data_in = 32'h77;
    cycle();
    check_outs("ts7", 1'b1, 32'h77, 3'd1, 1'b0);
    check("ts7 rd_time", 32'(rd_time), 32'd7);
    rd_ready = 1'b1;
    repeat (65528) cycle();
    rd_ready = 1'b0; data_in = 32'h88;
    cycle();
    check_outs("tswrap", 1'b1, 32'h88, 3'd1, 1'b0);
    check("tswrap rd_time", 32'(rd_time), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_capture.md
DATA_CAPTURE -- requirements
Module: data_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 32, captured word width.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_in_i, input, WIDTH, monitored data stream (upstream data_out_o).
REQ-006 SHALL have port capture_en_i, input, 1, enables capture of changed words.
REQ-007 SHALL have port clr_i, input, 1, synchronous flush of FIFO and overflow flag.
REQ-008 SHALL have port rd_valid_o, output, 1, FIFO head valid.
REQ-009 SHALL have port rd_ready_i, input, 1, consumer accepts head.
REQ-010 SHALL have port rd_data_o, output, WIDTH, FIFO head word (first-word fall-through).
REQ-011 SHALL have port level_o, output, $clog2(DEPTH)+1, current fill level.
REQ-012 SHALL have port overflow_o, output, 1, sticky flag: change dropped because FIFO full.

Function
REQ-013 SHALL register data_in_i into prev_q on every edge, independent of capture_en_i.
REQ-014 SHALL detect a change at an edge when data_in_i != prev_q.
REQ-015 SHALL push data_in_i at that edge when change detected and capture_en_i=1 (push).
REQ-016 SHALL pop the head at an edge when rd_valid_o=1 and rd_ready_i=1 (pop).
REQ-017 SHALL assert rd_valid_o and present the word on rd_data_o in the cycle after its push edge (latency 1).
REQ-018 SHALL keep rd_data_o stable while rd_valid_o=1 and no pop occurs.
REQ-019 SHALL, when full and push without pop, drop the word, leave FIFO unchanged, set overflow_o.
REQ-020 SHALL, when full with simultaneous push and pop, perform both; level unchanged; no overflow.
REQ-021 SHALL, when empty, ignore rd_ready_i; simultaneous push only increments level.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL keep overflow_o set until clr_i or reset.
REQ-024 SHALL, on clr_i=1, empty the FIFO and clear overflow_o at that edge; clr_i overrides push and pop; prev_q still updates.
REQ-025 SHALL drive level_o = pushes minus pops since the last clear, range 0..DEPTH.

Reset
REQ-026 SHALL, while reset_n_i=0, force prev_q=0, level_o=0, rd_valid_o=0, overflow_o=0, pointers=0, rd_data_o=0.
REQ-027 SHALL discard all FIFO content on reset asserted mid-operation; first post-reset compare is against 0.

Configuration
REQ-028 SHALL, with macro DATA_CAPTURE_TIMESTAMP_EN defined, include a 16-bit free-running cycle counter (0 at reset, +1 per edge, wraps 0xFFFF->0x0000), store its value with each pushed word, and output it on extra port rd_time_o[15:0] aligned with rd_data_o.
REQ-029 SHALL, without DATA_CAPTURE_TIMESTAMP_EN, omit the counter, timestamp storage and rd_time_o port; all other behaviour identical.

Structure
REQ-030 SHALL place TS_WIDTH (16) and default WIDTH/DEPTH constants in package data_capture_pkg.
REQ-031 SHALL implement storage in one sub-module data_capture_fifo (synchronous FWFT FIFO, push/pop/clr, level, full/empty).
REQ-032 SHALL keep change detection, overflow and timestamp logic in data_capture.

Verification
REQ-033 SHALL test: reset release, data_in_i held 0 for 10 cycles -> rd_valid_o=0, level_o=0, overflow_o=0.
REQ-034 SHALL test: capture_en_i=1, data_in_i 0 -> 0x0000_00A5 -> rd_valid_o=1 one cycle later, rd_data_o=0x0000_00A5, level_o=1.
REQ-035 SHALL test: rd_ready_i=0, 5 successive distinct words with DEPTH=4 -> level_o=4, overflow_o=1, pops yield first 4 words in order.
REQ-036 SHALL test: full FIFO, rd_ready_i=1 with new change same edge -> level_o stays 4, overflow_o stays 0.
REQ-037 SHALL test: capture_en_i=0 while data changes 0x1->0x2 -> no push; clr_i with level_o=3 -> level_o=0, rd_valid_o=0 next cycle.
REQ-038 SHALL test (DATA_CAPTURE_TIMESTAMP_EN): change at cycle 7 after reset -> rd_time_o=7; counter wrap after 65536 cycles -> rd_time_o=0x0000.
